// File: rtl/vga_scan_addr.sv
// Raster scan + pixel-address generator feeding the pixR/pixG/pixB stores and driving the VGA pins.
// Latency: address on pix_ce edge N; px_out/hsync/vsync/blank_n for that pixel on pix_ce edge N+1.
// Backpressure: none; free-running scan, the store must answer within one clk of an address change.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   pix_val[7:0]        byte returned by the store, valid 1 clk after the address changes
//   pat_en              (TEST_PATTERN_EN builds only) 1 = output 8 vertical test bars instead of pix_val
//   indxpix/indypix     active column/line of the stage A address (0 outside the active area)
//   indpix              linear index indxpix + indypix*H_ACTIVE
//   px_out[7:0]         channel byte to the DAC, 0 while blanked
//   hsync/vsync         active-low syncs, aligned with blank_n and px_out
//   blank_n             1 = px_out is visible
//   pix_ce              one-clk pixel enable, every CLK_DIV clks
//   frame_start         one-clk pulse on the pix_ce cycle whose edge addresses pixel (0,0)
//
// Optional feature macro: TEST_PATTERN_EN (adds the pat_en input and the bar generator).
module vga_scan_addr #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pix_val,
`ifdef TEST_PATTERN_EN
   input  logic       pat_en,
`endif
   output int         indxpix,
   output int         indypix,
   output int         indpix,
   output logic [7:0] px_out,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       pix_ce,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = ($clog2(H_TOTAL + 1) > 10) ? $clog2(H_TOTAL + 1) : 10;
   localparam int VW = ($clog2(V_TOTAL + 1) > 10) ? $clog2(V_TOTAL + 1) : 10;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

   // A divider of 1 would let stage B sample pix_val before the store has answered.
   if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_clk_div
      $error("vga_scan_addr: CLK_DIV must be in 2..16");
   end

   logic [3:0]    div_q, div_d;
   logic          pce_q, pce_d;
   logic          fs_q, fs_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   // stage A: address plus the sync/blank flags of the pixel being fetched
   int            indx_q, indx_d, indy_q, indy_d, idx_q, idx_d;
   logic          hs_a_q, hs_a_d, vs_a_q, vs_a_d, act_a_q, act_a_d;
   // stage B: pin-facing registers
   logic [7:0]    px_q, px_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic          act;
`ifdef TEST_PATTERN_EN
   int            bar;
`endif

   always_comb begin
      div_d   = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      pce_d   = (div_q == DIV_LAST);
      // asserted together with the pix_ce that will register (0,0) into stage A
      fs_d    = pce_d && (h_q == '0) && (v_q == '0);
      h_d     = h_q;
      v_d     = v_q;
      indx_d  = indx_q;
      indy_d  = indy_q;
      idx_d   = idx_q;
      hs_a_d  = hs_a_q;
      vs_a_d  = vs_a_q;
      act_a_d = act_a_q;
      px_d    = px_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      blank_d = blank_q;
      act     = (h_q < H_ACT) && (v_q < V_ACT);
`ifdef TEST_PATTERN_EN
      bar     = indx_q / (H_ACTIVE / 8);
`endif
      if (pce_q) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
         // outside the active area read address 0, which is harmless
         indx_d  = act ? int'(h_q) : 0;
         indy_d  = act ? int'(v_q) : 0;
         idx_d   = act ? int'(h_q) + int'(v_q) * H_ACTIVE : 0;
         hs_a_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
         vs_a_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
         act_a_d = act;
         // pix_val now answers the stage A address held since the previous pix_ce
         px_d    = act_a_q ? pix_val : 8'd0;
`ifdef TEST_PATTERN_EN
         if (pat_en) px_d = act_a_q ? 8'(bar * 32) : 8'd0;
`endif
         hsync_d = hs_a_q;
         vsync_d = vs_a_q;
         blank_d = act_a_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         pce_q   <= 1'b0;
         fs_q    <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         indx_q  <= 0;
         indy_q  <= 0;
         idx_q   <= 0;
         hs_a_q  <= 1'b1;
         vs_a_q  <= 1'b1;
         act_a_q <= 1'b0;
         px_q    <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         pce_q   <= pce_d;
         fs_q    <= fs_d;
         h_q     <= h_d;
         v_q     <= v_d;
         indx_q  <= indx_d;
         indy_q  <= indy_d;
         idx_q   <= idx_d;
         hs_a_q  <= hs_a_d;
         vs_a_q  <= vs_a_d;
         act_a_q <= act_a_d;
         px_q    <= px_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= blank_d;
      end
   end

   assign indxpix     = indx_q;
   assign indypix     = indy_q;
   assign indpix      = idx_q;
   assign px_out      = px_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_q;
   assign pix_ce      = pce_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_addr.sv
// Bench for vga_scan_addr: two instances (CLK_DIV 2 and 4) on a shrunken raster,
// a random-content pixel store, and a per-pixel scoreboard fed by a frame-position model.
module tb_vga_scan_addr;
   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int DIV0 = 2, DIV1 = 4;

   typedef struct {
      int h, v, x, y, idx, act, hs, vs;
   } pix_t;

   typedef struct {
      time t;
      int  fs, ax, ay, aidx, px, hs, vs, bn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pix_val [2];
   int         indx [2], indy [2], idx [2];
   logic [7:0] px [2];
   logic       hs [2], vs [2], bn [2], pce [2], fs [2];
   logic [7:0] lut [256];
   int         pat_mode = 0;
`ifdef TEST_PATTERN_EN
   logic       pat_en = 1'b0;
`endif

   exp_t q0 [$];
   exp_t q1 [$];
   int   e_cnt [2];
   int   n_checks = 0, n_fail = 0;
   bit   rst_prev = 1'b1;
   bit   done = 1'b0, done_chk = 1'b0;

   always #5 clk = ~clk;

   vga_scan_addr #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CLK_DIV(DIV0)) u_dut0 (
      .clk(clk), .rst(rst), .pix_val(pix_val[0]),
`ifdef TEST_PATTERN_EN
      .pat_en(pat_en),
`endif
      .indxpix(indx[0]), .indypix(indy[0]), .indpix(idx[0]), .px_out(px[0]),
      .hsync(hs[0]), .vsync(vs[0]), .blank_n(bn[0]), .pix_ce(pce[0]), .frame_start(fs[0]));

   vga_scan_addr #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CLK_DIV(DIV1)) u_dut1 (
      .clk(clk), .rst(rst), .pix_val(pix_val[1]),
`ifdef TEST_PATTERN_EN
      .pat_en(pat_en),
`endif
      .indxpix(indx[1]), .indypix(indy[1]), .indpix(idx[1]), .px_out(px[1]),
      .hsync(hs[1]), .vsync(vs[1]), .blank_n(bn[1]), .pix_ce(pce[1]), .frame_start(fs[1]));

   // Pixel store: answers one clk after the address, from random contents.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) pix_val[i] = lut[idx[i][7:0]];
   end

   // Where pixel number k after reset lies in the raster, straight from the timing rules.
   function automatic pix_t ref_pix(int k);
      pix_t r;
      r.h   = k % HT;
      r.v   = (k / HT) % VT;
      r.act = (r.h < HA && r.v < VA) ? 1 : 0;
      r.x   = r.act ? r.h : 0;
      r.y   = r.act ? r.v : 0;
      r.idx = r.x + r.y * HA;
      r.hs  = (r.h >= HA + HFP && r.h < HA + HFP + HS) ? 0 : 1;
      r.vs  = (r.v >= VA + VFP && r.v < VA + VFP + VS) ? 0 : 1;
      return r;
   endfunction

   // Expected pins during the k-th pix_ce cycle: stage A shows pixel k-1, stage B pixel k-2.
   function automatic exp_t make_exp(int k, time stamp);
      exp_t r;
      pix_t cur, a, b;
      cur = ref_pix(k);
      r.t  = stamp;
      r.fs = (cur.h == 0 && cur.v == 0) ? 1 : 0;
      r.ax = 0; r.ay = 0; r.aidx = 0;
      r.hs = 1; r.vs = 1; r.bn = 0; r.px = 0;
      if (k >= 1) begin
         a = ref_pix(k - 1);
         r.ax = a.x; r.ay = a.y; r.aidx = a.idx;
      end
      if (k >= 2) begin
         b = ref_pix(k - 2);
         r.hs = b.hs; r.vs = b.vs; r.bn = b.act;
         if (b.act != 0) r.px = pat_mode ? (b.x / (HA / 8)) * 32 : int'(lut[b.idx[7:0]]);
      end
      return r;
   endfunction

   // Reference: counts clks since reset release and queues one expectation per pixel period.
   always @(posedge clk) begin
      if (rst) begin
         e_cnt[0] = 0;
         e_cnt[1] = 0;
`ifdef TEST_PATTERN_EN
         pat_mode = int'(pat_en);
`endif
      end else begin
         e_cnt[0]++;
         e_cnt[1]++;
         if (e_cnt[0] % DIV0 == 0) q0.push_back(make_exp(e_cnt[0] / DIV0 - 1, $time + 5));
         if (e_cnt[1] % DIV1 == 0) q1.push_back(make_exp(e_cnt[1] / DIV1 - 1, $time + 5));
      end
   end

   task automatic chk(string name, int d, int got, int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, got, want);
      end
   endtask

   // Monitor: pops one expectation per observed pix_ce; checks reset state after a reset edge.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (rst_prev) begin
            chk("rst_pix_ce", i, int'(pce[i]), 0);
            chk("rst_frame_start", i, int'(fs[i]), 0);
            chk("rst_indxpix", i, indx[i], 0);
            chk("rst_indypix", i, indy[i], 0);
            chk("rst_indpix", i, idx[i], 0);
            chk("rst_px_out", i, int'(px[i]), 0);
            chk("rst_hsync", i, int'(hs[i]), 1);
            chk("rst_vsync", i, int'(vs[i]), 1);
            chk("rst_blank_n", i, int'(bn[i]), 0);
            chk("rst_pending_pixels", i, (i == 0) ? q0.size() : q1.size(), 0);
            if (i == 0) q0.delete(); else q1.delete();
         end else if (pce[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
               chk("unexpected_pix_ce", i, 1, 0);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               chk("pix_ce_time", i, int'($time), int'(e.t));
               chk("frame_start", i, int'(fs[i]), e.fs);
               chk("indxpix", i, indx[i], e.ax);
               chk("indypix", i, indy[i], e.ay);
               chk("indpix", i, idx[i], e.aidx);
               chk("px_out", i, int'(px[i]), e.px);
               chk("hsync", i, int'(hs[i]), e.hs);
               chk("vsync", i, int'(vs[i]), e.vs);
               chk("blank_n", i, int'(bn[i]), e.bn);
            end
         end else begin
            chk("frame_start_off_ce", i, int'(fs[i]), 0);
         end
      end
      rst_prev = rst;
      if (done && !done_chk) begin
         done_chk = 1'b1;
         chk("missed_pix_ce", 0, q0.size(), 0);
         chk("missed_pix_ce", 1, q1.size(), 0);
      end
   end

   task automatic pulse_reset(int n, int pat);
      @(posedge clk);
      #2;
      rst = 1'b1;
`ifdef TEST_PATTERN_EN
      pat_en = pat[0];
`else
      if (pat < 0) rst = 1'b1;
`endif
      repeat (n) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
      pix_val[0] = 8'd0;
      pix_val[1] = 8'd0;
      // power-on reset held for 3 clks
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (1100) @(posedge clk);
      // reset landing mid-frame
      repeat ($urandom_range(50, 400)) @(posedge clk);
      pulse_reset(1, 1);
      repeat (1000 + $urandom_range(0, 200)) @(posedge clk);
      pulse_reset($urandom_range(1, 3), int'($urandom_range(0, 1)));
      repeat (1300) @(posedge clk);
      done = 1'b1;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
